// File: rtl/byte_bus_arbiter.sv
// byte_bus_arbiter
//   Shares the single 8-bit external RAM/IO bus between the instruction-cache
//   refill path (always 4-byte reads) and the load/store buffer (1/2/4-byte
//   loads and stores). Multi-byte transfers are serialised into byte cycles
//   and read bytes are assembled little-endian. The RAM returns read data one
//   cycle after it samples mem_a.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   rdy               global ready; low freezes the block and masks mem_wr
//   rollback          flush: aborts reads in flight, never writes
//   if_req/if_addr    fetch request; if_valid/if_data fetch completion
//   ls_req/ls_wr/ls_addr/ls_size/ls_wdata
//                     LSB request; ls_valid/ls_rdata LSB completion
//   io_buffer_full    UART TX buffer full: holds off IO stores
//   mem_din           RAM read byte
//   mem_dout/mem_a/mem_wr
//                     RAM write byte, address and write enable
module byte_bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int IO_SEL_HI  = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  rollback,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_valid,
    output logic [31:0]           if_data,
    input  logic                  ls_req,
    input  logic                  ls_wr,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [1:0]            ls_size,
    input  logic [31:0]           ls_wdata,
    output logic                  ls_valid,
    output logic [31:0]           ls_rdata,
    input  logic                  io_buffer_full,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_e;

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;        // index of the upcoming edge Ek
    logic [2:0]            len_q, len_d;        // transfer length in bytes
    logic                  is_ls_q, is_ls_d;    // owner: 1 = LSB, 0 = fetch
    logic                  replay_q, replay_d;  // read interrupted by rdy low
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           buf_q, buf_d;        // partially assembled read word
    logic [31:0]           if_data_q, if_data_d;
    logic [31:0]           ls_rdata_q, ls_rdata_d;
    logic [7:0]            mem_dout_q, mem_dout_d;
    logic                  mem_wr_q, mem_wr_d;
    logic                  if_valid_q, if_valid_d;
    logic                  ls_valid_q, ls_valid_d;

    logic       ls_ok, can_accept, take_ls, take_if, read_done, write_done;
    logic [2:0] ls_len;

    // Acceptance: no accept while a valid pulse is out, which yields the
    // one-cycle gap after every completion.
    always_comb begin
        ls_ok      = ls_req && !(ls_wr && (ls_addr[IO_SEL_HI -: 2] == 2'b11) && io_buffer_full);
        can_accept = (state_q == S_IDLE) && rdy && !rollback && !if_valid_q && !ls_valid_q;
        take_ls    = can_accept && ls_ok;
        take_if    = can_accept && !ls_ok && if_req;
        read_done  = (cnt_q == len_q + 3'd1);
        write_done = (cnt_q == len_q);
        unique case (ls_size)
            2'd0:    ls_len = 3'd1;
            2'd1:    ls_len = 3'd2;
            default: ls_len = 3'd4;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (take_ls)      state_d = ls_wr ? S_WRITE : S_READ;
                else if (take_if) state_d = S_READ;
            end
            S_READ: begin
                if (rollback || (rdy && !replay_q && read_done)) state_d = S_IDLE;
            end
            S_WRITE: begin
                if (rdy && write_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath / output next values
    always_comb begin
        cnt_d      = cnt_q;
        len_d      = len_q;
        is_ls_d    = is_ls_q;
        replay_d   = replay_q;
        base_d     = base_q;
        mem_a_d    = mem_a_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        if_valid_d = rdy ? 1'b0 : if_valid_q;
        ls_valid_d = rdy ? 1'b0 : ls_valid_q;

        unique case (state_q)
            S_IDLE: begin
                if (take_ls || take_if) begin
                    is_ls_d  = take_ls;
                    base_d   = take_ls ? ls_addr : if_addr;
                    len_d    = take_ls ? ls_len : 3'd4;
                    wdata_d  = ls_wdata;
                    mem_a_d  = take_ls ? ls_addr : if_addr;
                    mem_wr_d = take_ls && ls_wr;
                    cnt_d    = 3'd1;
                    buf_d    = '0;
                    replay_d = 1'b0;
                    if (take_ls && ls_wr) mem_dout_d = ls_wdata[7:0];
                end
            end
            S_READ: begin
                if (rollback) begin
                    mem_a_d  = '0;
                    buf_d    = '0;
                    cnt_d    = '0;
                    replay_d = 1'b0;
                end else if (!rdy) begin
                    replay_d = 1'b1;
                end else if (replay_q) begin
                    // Restart from E0: earlier bytes may be stale after the pause.
                    mem_a_d  = base_q;
                    buf_d    = '0;
                    cnt_d    = 3'd1;
                    replay_d = 1'b0;
                end else begin
                    if (cnt_q < len_q) mem_a_d = base_q + ADDR_WIDTH'(cnt_q);
                    // Byte i arrives at edge E(i+2).
                    for (int unsigned i = 0; i < 4; i++) begin
                        if ({29'd0, cnt_q} == i + 2) buf_d[8*i +: 8] = mem_din;
                    end
                    if (read_done) begin
                        mem_a_d = '0;
                        cnt_d   = '0;
                        if (is_ls_q) begin
                            ls_valid_d = 1'b1;
                            ls_rdata_d = buf_d;
                        end else begin
                            if_valid_d = 1'b1;
                            if_data_d  = buf_d;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            S_WRITE: begin
                if (rdy) begin
                    if (!write_done) begin
                        mem_a_d    = base_q + ADDR_WIDTH'(cnt_q);
                        mem_dout_d = 8'(wdata_q >> {cnt_q, 3'b000});
                        mem_wr_d   = 1'b1;
                        cnt_d      = cnt_q + 3'd1;
                    end else begin
                        mem_a_d    = '0;
                        mem_wr_d   = 1'b0;
                        cnt_d      = '0;
                        ls_valid_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            len_q      <= '0;
            is_ls_q    <= 1'b0;
            replay_q   <= 1'b0;
            base_q     <= '0;
            mem_a_q    <= '0;
            wdata_q    <= '0;
            buf_q      <= '0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            if_valid_q <= 1'b0;
            ls_valid_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            is_ls_q    <= is_ls_d;
            replay_q   <= replay_d;
            base_q     <= base_d;
            mem_a_q    <= mem_a_d;
            wdata_q    <= wdata_d;
            buf_q      <= buf_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            if_valid_q <= if_valid_d;
            ls_valid_q <= ls_valid_d;
        end
    end

    // Output process
    always_comb begin
        mem_wr   = mem_wr_q && rdy;  // a paused write must not strobe the RAM
        mem_a    = mem_a_q;
        mem_dout = mem_dout_q;
        if_valid = if_valid_q;
        if_data  = if_data_q;
        ls_valid = ls_valid_q;
        ls_rdata = ls_rdata_q;
    end

endmodule

// File: tb/tb_byte_bus_arbiter.sv
// Bench for byte_bus_arbiter: a byte RAM with one-cycle read latency, a
// transaction-level model (expected memory image, expected word per request),
// a per-cycle compare process, and directed scenarios with literal values.
module tb_byte_bus_arbiter;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst, rdy, rollback, if_req, ls_req, ls_wr, io_buffer_full;
    logic [AW-1:0] if_addr, ls_addr, mem_a;
    logic [1:0]    ls_size;
    logic [31:0]   ls_wdata, if_data, ls_rdata;
    logic          if_valid, ls_valid, mem_wr;
    logic [7:0]    mem_din, mem_dout;

    always #5 clk = ~clk;

    byte_bus_arbiter #(.ADDR_WIDTH(AW), .IO_SEL_HI(17)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_data(if_data),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_size(ls_size),
        .ls_wdata(ls_wdata), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
        .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] PRE_A [10] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h200,
                                           32'h201, 32'h500, 32'h501, 32'h502, 32'h503};
    localparam logic [7:0]  PRE_D [10] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'hAB,
                                           8'hCD, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

    logic [7:0] ram     [bit [31:0]];
    logic [7:0] exp_mem [bit [31:0]];

    typedef struct packed {logic rdy; logic [31:0] a; logic [7:0] d;} wr_t;
    wr_t wq[$];

    // Model of the transaction currently owned by each requester
    logic [31:0] m_if_addr = '0, m_ls_addr = '0, m_ls_wdata = '0;
    logic [1:0]  m_ls_size = '0;
    logic        m_ls_wr = 1'b0;
    int          if_pulses = 0, ls_pulses = 0, wcnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic logic [7:0] exp_rd(input logic [31:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : 8'h00;
    endfunction

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    // Little-endian word of n bytes from the expected memory, zero-extended
    function automatic logic [31:0] model_word(input logic [31:0] a, input int n);
        logic [31:0] w = '0;
        for (int i = 0; i < n; i++) w = w | (32'(exp_rd(a + 32'(i))) << (8 * i));
        return w;
    endfunction

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return {ram_rd(a + 32'd3), ram_rd(a + 32'd2), ram_rd(a + 32'd1), ram_rd(a)};
    endfunction

    // External RAM: write at the edge, read data appears one cycle after mem_a
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 10; i++) ram[PRE_A[i]] = PRE_D[i];
        end
        if (mem_wr) begin
            ram[mem_a] = mem_dout;
            wq.push_back({rdy, mem_a, mem_dout});
        end
        mem_din <= ram_rd(mem_a);
    end

    // Compare process
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 10; i++) exp_mem[PRE_A[i]] = PRE_D[i];
        end
        while (wq.size() > 0) begin
            wr_t         w;
            logic [31:0] idx;
            w   = wq.pop_front();
            idx = w.a - m_ls_addr;
            check("wr_while_ready", {31'd0, w.rdy}, 32'd1);
            check("wr_in_range", {31'd0, idx < 32'(nbytes(m_ls_size))}, 32'd1);
            check("wr_byte", {24'd0, w.d}, {24'd0, 8'(m_ls_wdata >> (8 * idx))});
            wcnt++;
        end
        if (if_valid) begin
            if_pulses++;
            check("if_data_model", if_data, model_word(m_if_addr, 4));
        end
        if (ls_valid) begin
            ls_pulses++;
            if (m_ls_wr) begin
                for (int i = 0; i < nbytes(m_ls_size); i++) begin
                    exp_mem[m_ls_addr + 32'(i)] = 8'(m_ls_wdata >> (8 * i));
                    check("st_ram_model", {24'd0, ram_rd(m_ls_addr + 32'(i))},
                          {24'd0, exp_rd(m_ls_addr + 32'(i))});
                end
                check("st_byte_count", 32'(wcnt), 32'(nbytes(m_ls_size)));
                wcnt = 0;
            end else begin
                check("ld_data_model", ls_rdata, model_word(m_ls_addr, nbytes(m_ls_size)));
            end
        end
    end

    task automatic wait_valid(input bit want_ls, input string name);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (want_ls ? ls_valid : if_valid) break;
        end
        check(name, {31'd0, want_ls ? ls_valid : if_valid}, 32'd1);
    endtask

    task automatic ls_start(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                            input logic [31:0] wd);
        ls_req = 1'b1; ls_wr = wr; ls_addr = a; ls_size = sz; ls_wdata = wd;
        m_ls_wr = wr; m_ls_addr = a; m_ls_size = sz; m_ls_wdata = wd;
    endtask

    task automatic if_start(input logic [31:0] a);
        if_req = 1'b1; if_addr = a; m_if_addr = a;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; if_req = 1'b0; ls_req = 1'b0;
        ls_wr = 1'b0; io_buffer_full = 1'b0; if_addr = '0; ls_addr = '0;
        ls_size = '0; ls_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_ls_valid", {31'd0, ls_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Fetch 0x100: address walk, 6-cycle latency, single pulse, no re-accept
        if_start(32'h100);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("fetch_addr", mem_a, 32'h100 + 32'(k - 1));
            check("fetch_wr", {31'd0, mem_wr}, 32'd0);
        end
        @(negedge clk);
        check("fetch_early", {31'd0, if_valid}, 32'd0);
        @(negedge clk);
        check("fetch_valid", {31'd0, if_valid}, 32'd1);
        check("fetch_data", if_data, 32'h00100513);
        @(negedge clk);
        check("fetch_pulse", {31'd0, if_valid}, 32'd0);
        check("fetch_no_reaccept", mem_a, 32'd0);
        if_req = 1'b0;
        @(negedge clk);

        // Arbitration: load half wins, fetch follows after the gap
        ls_start(1'b0, 32'h200, 2'd1, 32'd0);
        if_start(32'h100);
        wait_valid(1'b1, "arb_ls_done");
        check("arb_ls_data", ls_rdata, 32'h0000CDAB);
        check("arb_if_waits", {31'd0, if_valid}, 32'd0);
        ls_req = 1'b0;
        @(negedge clk);
        check("arb_gap", mem_a, 32'd0);
        @(negedge clk);
        check("arb_if_start", mem_a, 32'h100);
        wait_valid(1'b0, "arb_if_done");
        check("arb_if_data", if_data, 32'h00100513);
        if_req = 1'b0;
        @(negedge clk);

        // IO store stalled by a full UART buffer
        io_buffer_full = 1'b1;
        ls_start(1'b1, 32'h30000, 2'd0, 32'h41);
        repeat (5) begin
            @(negedge clk);
            check("io_stall_wr", {31'd0, mem_wr}, 32'd0);
            check("io_stall_a", mem_a, 32'd0);
        end
        io_buffer_full = 1'b0;
        @(negedge clk);
        check("io_wr", {31'd0, mem_wr}, 32'd1);
        check("io_a", mem_a, 32'h30000);
        check("io_dout", {24'd0, mem_dout}, 32'h41);
        @(negedge clk);
        check("io_valid", {31'd0, ls_valid}, 32'd1);
        check("io_wr_off", {31'd0, mem_wr}, 32'd0);
        ls_req = 1'b0; ls_wr = 1'b0;
        @(negedge clk);

        // Rollback at E2 of a fetch
        if_start(32'h100);
        @(negedge clk);
        @(negedge clk);
        rollback = 1'b1; if_req = 1'b0;
        @(negedge clk);
        rollback = 1'b0;
        check("rb_addr", mem_a, 32'd0);
        repeat (6) begin
            @(negedge clk);
            check("rb_no_valid", {31'd0, if_valid}, 32'd0);
            check("rb_idle", mem_a, 32'd0);
        end

        // Rollback during a word store does not abort it
        ls_start(1'b1, 32'h400, 2'd2, 32'h11223344);
        @(negedge clk);
        check("rbst_wr", {31'd0, mem_wr}, 32'd1);
        @(negedge clk);
        rollback = 1'b1;
        @(negedge clk);
        rollback = 1'b0;
        wait_valid(1'b1, "rbst_done");
        check("rbst_ram", ram_word(32'h400), 32'h11223344);
        ls_req = 1'b0; ls_wr = 1'b0;
        @(negedge clk);

        // rdy low for 3 cycles mid word-read: replay from base
        ls_start(1'b0, 32'h500, 2'd2, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rdy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rdy_rd_wr", {31'd0, mem_wr}, 32'd0);
            check("rdy_rd_hold", {31'd0, ls_valid}, 32'd0);
        end
        rdy = 1'b1;
        @(negedge clk);
        check("rdy_replay_base", mem_a, 32'h500);
        wait_valid(1'b1, "rdy_rd_done");
        check("rdy_rd_data", ls_rdata, 32'hEFBEADDE);
        ls_req = 1'b0;
        @(negedge clk);

        // rdy low mid word-store
        ls_start(1'b1, 32'h600, 2'd2, 32'hA5B6C7D8);
        @(negedge clk);
        @(negedge clk);
        rdy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rdy_wr_forced", {31'd0, mem_wr}, 32'd0);
        end
        rdy = 1'b1;
        wait_valid(1'b1, "rdy_wr_done");
        check("rdy_wr_ram", ram_word(32'h600), 32'hA5B6C7D8);
        ls_req = 1'b0; ls_wr = 1'b0;
        @(negedge clk);

        // Reset at E2 of a word store, then a fresh fetch is accepted
        ls_start(1'b1, 32'h700, 2'd2, 32'h55667788);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstw_wr", {31'd0, mem_wr}, 32'd0);
        check("rstw_a", mem_a, 32'd0);
        check("rstw_valid", {31'd0, ls_valid}, 32'd0);
        rst = 1'b0; ls_req = 1'b0; ls_wr = 1'b0;
        if_start(32'h100);
        wait_valid(1'b0, "rstw_fetch_done");
        check("rstw_fetch_data", if_data, 32'h00100513);
        if_req = 1'b0;
        repeat (2) @(negedge clk);

        check("if_pulse_total", 32'(if_pulses), 32'd3);
        check("ls_pulse_total", 32'(ls_pulses), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
